alu_share_arbiter: RTL and testbench

- Shares one combinational IALU (WIDTH=32, 5-bit op) between NUM_REQ requesters, e.g. the core execute stage and a debug/CSR-side or address-gen requester.
- Each requester uses a valid/ready request channel and a valid/ready response channel.
- Grants are round-robin. The ALU result is captured into a response register and held under backpressure.
- Sustains one operation per cycle when responses are consumed immediately.

---
 rtl/alu_pkg.sv | 30 +++
 rtl/rr_arbiter.sv | 39 +++
 rtl/alu_share_arbiter.sv | 145 ++++++++++++++
 tb/tb_alu_share_arbiter.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the integer ALU and its users: the op-code width,
// the op-code values understood by the IALU, and the state type of the ALU
// share arbiter.
// No ports (package).
// ---------------------------------------------------------------------------
package alu_pkg;

   localparam int ALU_OPW = 5;

   localparam logic [ALU_OPW-1:0] ALU_ADD  = 5'd0;
   localparam logic [ALU_OPW-1:0] ALU_SUB  = 5'd1;
   localparam logic [ALU_OPW-1:0] ALU_AND  = 5'd2;
   localparam logic [ALU_OPW-1:0] ALU_OR   = 5'd3;
   localparam logic [ALU_OPW-1:0] ALU_XOR  = 5'd4;
   localparam logic [ALU_OPW-1:0] ALU_SLL  = 5'd5;
   localparam logic [ALU_OPW-1:0] ALU_SRL  = 5'd6;
   localparam logic [ALU_OPW-1:0] ALU_SRA  = 5'd7;
   localparam logic [ALU_OPW-1:0] ALU_SLT  = 5'd8;
   localparam logic [ALU_OPW-1:0] ALU_SLTU = 5'd9;

   // IDLE: no response held. RESP: a response register is waiting for its
   // owner's rsp_ready.
   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RESP = 1'b1
   } arbState_e;

endpackage

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin arbiter. Scans the request vector starting at
// the index after i_lastGrant, wrapping modulo NUM_REQ, and grants the first
// active request. No grant is produced while i_enable is low.
// Ports:
//   i_req        NUM_REQ        request vector
//   i_lastGrant  $clog2(NUM_REQ) index granted most recently
//   i_enable     1              allow a grant this cycle
//   o_grant      NUM_REQ        one-hot grant (all zero when none)
// ---------------------------------------------------------------------------
module rr_arbiter #(
   parameter int NUM_REQ = 2,
   parameter int IDW     = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] i_req,
   input  logic [IDW-1:0]     i_lastGrant,
   input  logic               i_enable,
   output logic [NUM_REQ-1:0] o_grant
);

   // Walk the requesters in priority order (last winner gets lowest
   // priority) and stop at the first active one.
   always_comb begin
      logic found;
      int   idx;
      o_grant = '0;
      found   = 1'b0;
      idx     = 0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         idx = (int'(i_lastGrant) + k) % NUM_REQ;
         if (i_enable && !found && i_req[idx]) begin
            o_grant[idx] = 1'b1;
            found        = 1'b1;
         end
      end
   end

endmodule

// File: rtl/alu_share_arbiter.sv
// ---------------------------------------------------------------------------
// alu_share_arbiter
// Shares one combinational IALU between NUM_REQ requesters. Requests are
// granted round-robin; the ALU result is captured into a response register
// that is held until its owner accepts it. A new request may be granted in
// the same cycle the current response is accepted, giving one op per cycle.
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   req_valid    NUM_REQ         request valid per requester
//   req_ready    NUM_REQ         one-hot grant (combinational)
//   req_a/req_b  NUM_REQ*WIDTH   packed operands, requester i at [i*WIDTH +: WIDTH]
//   req_op       NUM_REQ*OPW     packed op codes
//   alu_a/b/op   to the IALU (zero when nothing is granted)
//   alu_result   from the IALU
//   rsp_valid    NUM_REQ         one-hot response valid
//   rsp_ready    NUM_REQ         response accept per requester
//   rsp_result   WIDTH           shared response data
//   rsp_id       $clog2(NUM_REQ) owner of the current response
// ---------------------------------------------------------------------------
module alu_share_arbiter
   import alu_pkg::*;
#(
   parameter int NUM_REQ = 2,
   parameter int WIDTH   = 32,
   parameter int OPW     = ALU_OPW,
   parameter int IDW     = $clog2(NUM_REQ)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_REQ-1:0]       req_valid,
   output logic [NUM_REQ-1:0]       req_ready,
   input  logic [NUM_REQ*WIDTH-1:0] req_a,
   input  logic [NUM_REQ*WIDTH-1:0] req_b,
   input  logic [NUM_REQ*OPW-1:0]   req_op,
   output logic [WIDTH-1:0]         alu_a,
   output logic [WIDTH-1:0]         alu_b,
   output logic [OPW-1:0]           alu_op,
   input  logic [WIDTH-1:0]         alu_result,
   output logic [NUM_REQ-1:0]       rsp_valid,
   input  logic [NUM_REQ-1:0]       rsp_ready,
   output logic [WIDTH-1:0]         rsp_result,
   output logic [IDW-1:0]           rsp_id
);

   arbState_e          r_state;
   arbState_e          w_nextState;
   logic [NUM_REQ-1:0] r_rspValid;
   logic [WIDTH-1:0]   r_rspResult;
   logic [IDW-1:0]     r_rspId;
   logic [IDW-1:0]     r_lastGrant;
   logic               w_canIssue;
   logic               w_ownerReady;
   logic               w_anyGrant;
   logic [NUM_REQ-1:0] w_grant;
   logic [IDW-1:0]     w_grantId;

   // Only the owner's rsp_ready can free the response register; reset
   // blocks every handshake in the reset cycle.
   assign w_ownerReady = rsp_ready[r_rspId];
   assign w_canIssue   = ~rst & ((r_state == ST_IDLE) |
                                 ((r_state == ST_RESP) & w_ownerReady));

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .IDW     (IDW)
   ) u_rrArbiter (
      .i_req       (req_valid),
      .i_lastGrant (r_lastGrant),
      .i_enable    (w_canIssue),
      .o_grant     (w_grant)
   );

   assign req_ready  = w_grant;
   assign w_anyGrant = |w_grant;
   assign rsp_valid  = r_rspValid;
   assign rsp_result = r_rspResult;
   assign rsp_id     = r_rspId;

   // Convert the one-hot grant to an index and steer the winner's operands
   // onto the ALU; an idle ALU sees all zeros so it does not toggle.
   always_comb begin
      w_grantId = '0;
      alu_a     = '0;
      alu_b     = '0;
      alu_op    = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (w_grant[i]) begin
            w_grantId = IDW'(i);
            alu_a     = req_a[i*WIDTH +: WIDTH];
            alu_b     = req_b[i*WIDTH +: WIDTH];
            alu_op    = req_op[i*OPW +: OPW];
         end
      end
   end

   // Next-state logic: any grant (re)loads the response register; an
   // accepted response with nothing behind it returns to IDLE.
   always_comb begin
      w_nextState = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_anyGrant) begin
               w_nextState = ST_RESP;
            end
         end
         ST_RESP: begin
            if (w_anyGrant) begin
               w_nextState = ST_RESP;
            end else if (w_ownerReady) begin
               w_nextState = ST_IDLE;
            end
         end
         default: w_nextState = ST_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Response register and round-robin pointer. last_grant resets to the
   // highest index so requester 0 wins the first arbitration. rsp_result and
   // rsp_id keep their last values when the response is retired.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rspValid  <= '0;
         r_rspResult <= '0;
         r_rspId     <= '0;
         r_lastGrant <= IDW'(NUM_REQ - 1);
      end else if (w_anyGrant) begin
         r_rspValid  <= w_grant;
         r_rspResult <= alu_result;
         r_rspId     <= w_grantId;
         r_lastGrant <= w_grantId;
      end else if ((r_state == ST_RESP) && w_ownerReady) begin
         r_rspValid  <= '0;
      end
   end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// ---------------------------------------------------------------------------
// tb_alu_share_arbiter
// Self-checking bench for alu_share_arbiter with two requesters. A bench-side
// IALU stand-in closes the alu_* loop; a transaction-level model (pending
// response + round-robin pointer) predicts grants and responses.
// ---------------------------------------------------------------------------
module tb_alu_share_arbiter;
   import alu_pkg::*;

   localparam int NR  = 2;
   localparam int W   = 32;
   localparam int OW  = ALU_OPW;
   localparam int IDW = 1;

   logic            clk = 1'b0;
   logic            rst;
   logic [NR-1:0]   req_valid;
   logic [NR-1:0]   req_ready;
   logic [NR*W-1:0] req_a;
   logic [NR*W-1:0] req_b;
   logic [NR*OW-1:0] req_op;
   logic [W-1:0]    alu_a;
   logic [W-1:0]    alu_b;
   logic [OW-1:0]   alu_op;
   logic [W-1:0]    alu_result;
   logic [NR-1:0]   rsp_valid;
   logic [NR-1:0]   rsp_ready;
   logic [W-1:0]    rsp_result;
   logic [IDW-1:0]  rsp_id;

   // Requester-side state
   logic            tbValid [NR];
   logic [31:0]     tbA     [NR];
   logic [31:0]     tbB     [NR];
   logic [4:0]      tbOp    [NR];

   // Reference model state
   logic            mValid;
   int              mId;
   logic [31:0]     mResult;
   int              mLast;

   int              checks = 0;
   int              errors = 0;

   always #5 clk = ~clk;

   // Behavioural integer ALU, used as the IALU stand-in and by the model.
   function automatic logic [31:0] aluRef(input logic [31:0] a, input logic [31:0] b,
                                          input logic [4:0] op);
      case (op)
         ALU_ADD:  return a + b;
         ALU_SUB:  return a - b;
         ALU_AND:  return a & b;
         ALU_OR:   return a | b;
         ALU_XOR:  return a ^ b;
         ALU_SLL:  return a << b[4:0];
         ALU_SRL:  return a >> b[4:0];
         ALU_SRA:  return 32'($signed(a) >>> b[4:0]);
         ALU_SLT:  return {31'b0, $signed(a) < $signed(b)};
         ALU_SLTU: return {31'b0, a < b};
         default:  return 32'h0;
      endcase
   endfunction

   assign alu_result = aluRef(alu_a, alu_b, alu_op);

   alu_share_arbiter #(
      .NUM_REQ (NR),
      .WIDTH   (W),
      .OPW     (OW)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_a      (req_a),
      .req_b      (req_b),
      .req_op     (req_op),
      .alu_a      (alu_a),
      .alu_b      (alu_b),
      .alu_op     (alu_op),
      .alu_result (alu_result),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_result (rsp_result),
      .rsp_id     (rsp_id)
   );

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
      end
   endtask

   // One clock cycle: drive inputs after the falling edge, check the
   // combinational grant/ALU drive, advance the model, then check the
   // registered response just after the rising edge. Returns the granted
   // requester, or -1 when nobody was granted.
   task automatic applyStimulus(input logic rstIn, input logic [NR-1:0] rdy,
                                output int gnt);
      int idx;
      @(negedge clk);
      rst       = rstIn;
      rsp_ready = rdy;
      for (int i = 0; i < NR; i++) begin
         req_valid[i]         = tbValid[i];
         req_a[i*W +: W]      = tbA[i];
         req_b[i*W +: W]      = tbB[i];
         req_op[i*OW +: OW]   = tbOp[i];
      end
      #1;
      gnt = -1;
      if (!rstIn && (!mValid || rdy[mId])) begin
         for (int k = 1; k <= NR; k++) begin
            idx = (mLast + k) % NR;
            if (gnt < 0 && tbValid[idx]) gnt = idx;
         end
      end
      checkOutput("req_ready", 32'(req_ready), (gnt < 0) ? 32'h0 : (32'h1 << gnt));
      checkOutput("alu_a",  alu_a,         (gnt < 0) ? 32'h0 : tbA[gnt]);
      checkOutput("alu_b",  alu_b,         (gnt < 0) ? 32'h0 : tbB[gnt]);
      checkOutput("alu_op", 32'(alu_op),   (gnt < 0) ? 32'h0 : 32'(tbOp[gnt]));
      if (rstIn) begin
         mValid  = 1'b0;
         mId     = 0;
         mResult = 32'h0;
         mLast   = NR - 1;
      end else if (gnt >= 0) begin
         mValid  = 1'b1;
         mId     = gnt;
         mResult = aluRef(tbA[gnt], tbB[gnt], tbOp[gnt]);
         mLast   = gnt;
      end else if (mValid && rdy[mId]) begin
         mValid  = 1'b0;
      end
      @(posedge clk);
      #1;
      checkOutput("rsp_valid",  32'(rsp_valid), mValid ? (32'h1 << mId) : 32'h0);
      checkOutput("rsp_id",     32'(rsp_id),    32'(mId));
      checkOutput("rsp_result", rsp_result,     mResult);
   endtask

   task automatic setReq(input int i, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] op);
      tbValid[i] = 1'b1;
      tbA[i]     = a;
      tbB[i]     = b;
      tbOp[i]    = op;
   endtask

   task automatic resetDut();
      int g;
      for (int i = 0; i < NR; i++) tbValid[i] = 1'b0;
      applyStimulus(1'b1, '0, g);
      applyStimulus(1'b1, '0, g);
   endtask

   initial begin
      int g;
      rst       = 1'b1;
      req_valid = '0;
      req_a     = '0;
      req_b     = '0;
      req_op    = '0;
      rsp_ready = '0;
      for (int i = 0; i < NR; i++) begin
         tbValid[i] = 1'b0;
         tbA[i]     = '0;
         tbB[i]     = '0;
         tbOp[i]    = '0;
      end
      mValid = 1'b0; mId = 0; mResult = '0; mLast = NR - 1;

      // Reset state
      resetDut();
      checkOutput("reset_rsp_valid", 32'(rsp_valid), 32'h0);

      // Single request: 5 + 7
      setReq(0, 32'd5, 32'd7, ALU_ADD);
      applyStimulus(1'b0, 2'b11, g);
      tbValid[0] = 1'b0;
      checkOutput("single_gnt", g, 32'd0);
      checkOutput("single_result", rsp_result, 32'd12);
      applyStimulus(1'b0, 2'b11, g);
      checkOutput("single_idle", 32'(rsp_valid), 32'h0);

      // Contention: grants alternate starting at requester 0
      resetDut();
      setReq(0, 32'd1, 32'd1, ALU_ADD);
      setReq(1, 32'd10, 32'd3, ALU_SUB);
      for (int c = 0; c < 6; c++) begin
         applyStimulus(1'b0, 2'b11, g);
         checkOutput("contend_gnt", g, 32'(c % 2));
         checkOutput("contend_res", rsp_result, (c % 2) ? 32'd7 : 32'd2);
      end
      tbValid[0] = 1'b0; tbValid[1] = 1'b0;

      // Backpressure on requester 1 while requester 0 waits
      resetDut();
      setReq(1, 32'd100, 32'd23, ALU_ADD);
      applyStimulus(1'b0, 2'b01, g);
      tbValid[1] = 1'b0;
      setReq(0, 32'd40, 32'd2, ALU_SUB);
      for (int c = 0; c < 4; c++) begin
         applyStimulus(1'b0, 2'b01, g);
         checkOutput("bp_stall", g, 32'hFFFF_FFFF);
         checkOutput("bp_hold", rsp_result, 32'd123);
         checkOutput("bp_valid", 32'(rsp_valid), 32'h2);
      end
      applyStimulus(1'b0, 2'b10, g);
      tbValid[0] = 1'b0;
      checkOutput("bp_release", g, 32'd0);
      checkOutput("bp_newres", rsp_result, 32'd38);

      // Wrong requester's ready must not retire the response
      resetDut();
      setReq(0, 32'h0000_00F0, 32'd4, ALU_SRL);
      applyStimulus(1'b0, 2'b00, g);
      tbValid[0] = 1'b0;
      setReq(1, 32'd10, 32'd3, ALU_SUB);
      for (int c = 0; c < 3; c++) begin
         applyStimulus(1'b0, 2'b10, g);
         checkOutput("wrong_rdy_gnt", g, 32'hFFFF_FFFF);
         checkOutput("wrong_rdy_res", rsp_result, 32'h0000_000F);
      end
      applyStimulus(1'b0, 2'b01, g);
      tbValid[1] = 1'b0;
      checkOutput("wrong_rdy_release", g, 32'd1);
      applyStimulus(1'b0, 2'b11, g);

      // Reset mid-operation
      resetDut();
      setReq(0, 32'd9, 32'd9, ALU_XOR);
      setReq(1, 32'd3, 32'd4, ALU_SLT);
      applyStimulus(1'b0, 2'b00, g);
      tbValid[0] = 1'b0;
      setReq(0, 32'hFFFF_FFFF, 32'd1, ALU_SLT);
      applyStimulus(1'b1, 2'b00, g);
      checkOutput("midrst_valid", 32'(rsp_valid), 32'h0);
      checkOutput("midrst_result", rsp_result, 32'h0);
      applyStimulus(1'b0, 2'b11, g);
      checkOutput("midrst_first_gnt", g, 32'd0);
      checkOutput("midrst_first_res", rsp_result, 32'd1);

      // Randomized traffic with random backpressure
      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < NR; i++) begin
            if (!tbValid[i] && $urandom_range(0, 2) != 0) begin
               setReq(i, $urandom, ($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 40)) : $urandom,
                      5'($urandom_range(0, 9)));
            end
         end
         applyStimulus(1'b0, 2'($urandom_range(0, 3)), g);
         if (g >= 0) tbValid[g] = 1'b0;
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
